// File: rtl/array_allocator.sv
// Array-slot allocator: hands out heap array ids, reusing freed ids LIFO before fresh ones.
// All responses are registered one-cycle pulses; an alloc paired with a valid free reuses freeId directly.
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          allocReq,
  input  logic                          freeReq,
  input  logic [MemoryElementWidth-1:0] freeId,
  output logic                          allocAck,
  output logic [MemoryElementWidth-1:0] allocId,
  output logic                          allocFail,
  output logic                          freeAck,
  output logic                          freeFail,
  output logic                          sizeClear,
  output logic [MemoryElementWidth-1:0] inUse,
  output logic [MemoryElementWidth-1:0] allocs
);
  localparam int W  = MemoryElementWidth;
  localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int TW = $clog2(NArrays + 1);

  logic [IW-1:0]      r_stack [NArrays];
  logic [TW-1:0]      r_top;
  logic [NArrays-1:0] r_bitmap;
  logic [W-1:0]       r_inUse, r_allocs;

  logic [IW-1:0]      n_stack [NArrays];
  logic [TW-1:0]      n_top;
  logic [NArrays-1:0] n_bitmap;
  logic [W-1:0]       n_inUse, n_allocs, n_allocId;
  logic               n_aack, n_afail, n_fack, n_ffail;

  logic [IW-1:0] w_free_idx, w_pop_idx, w_gid;
  logic          w_free_ok, w_grant;

  assign w_free_idx = freeId[IW-1:0];
  assign w_pop_idx  = IW'(r_top - TW'(1));
  assign w_free_ok  = freeReq && (freeId < W'(NArrays)) && r_bitmap[w_free_idx];

  always_comb begin
    n_stack   = r_stack;
    n_top     = r_top;
    n_bitmap  = r_bitmap;
    n_inUse   = r_inUse;
    n_allocs  = r_allocs;
    n_allocId = allocId;
    n_aack    = 1'b0;
    n_afail   = 1'b0;
    n_fack    = 1'b0;
    n_ffail   = 1'b0;
    w_grant   = 1'b0;
    w_gid     = '0;
    if (allocReq && w_free_ok) begin
      // bypass: the freed id goes straight back out, bookkeeping untouched
      n_aack    = 1'b1;
      n_fack    = 1'b1;
      n_allocId = freeId;
    end else begin
      // an invalid free changes no state, so alloc below can read r_* safely
      if (freeReq) begin
        if (w_free_ok) begin
          n_stack[IW'(r_top)]  = w_free_idx;
          n_top                = r_top + TW'(1);
          n_bitmap[w_free_idx] = 1'b0;
          n_inUse              = r_inUse - W'(1);
          n_fack               = 1'b1;
        end else begin
          n_ffail = 1'b1;
        end
      end
      if (allocReq) begin
        if (r_top != '0) begin
          n_top   = r_top - TW'(1);
          w_gid   = r_stack[w_pop_idx];
          w_grant = 1'b1;
        end else if (r_allocs < W'(NArrays)) begin
          w_gid    = IW'(r_allocs);
          n_allocs = r_allocs + W'(1);
          w_grant  = 1'b1;
        end
        if (w_grant) begin
          n_bitmap[w_gid] = 1'b1;
          n_inUse         = r_inUse + W'(1);
          n_aack          = 1'b1;
          n_allocId       = W'(w_gid);
        end else begin
          n_afail = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NArrays; i++) r_stack[i] <= '0;
      r_top     <= '0;
      r_bitmap  <= '0;
      r_inUse   <= '0;
      r_allocs  <= '0;
      allocId   <= '0;
      allocAck  <= 1'b0;
      allocFail <= 1'b0;
      freeAck   <= 1'b0;
      freeFail  <= 1'b0;
      sizeClear <= 1'b0;
    end else begin
      r_stack   <= n_stack;
      r_top     <= n_top;
      r_bitmap  <= n_bitmap;
      r_inUse   <= n_inUse;
      r_allocs  <= n_allocs;
      allocId   <= n_allocId;
      allocAck  <= n_aack;
      allocFail <= n_afail;
      freeAck   <= n_fack;
      freeFail  <= n_ffail;
      sizeClear <= n_aack;
    end
  end

  assign inUse  = r_inUse;
  assign allocs = r_allocs;
endmodule

// File: tb/tb_array_allocator.sv
// Scoreboard bench for array_allocator: a queue/set reference model predicts each response,
// a monitor pops and compares whenever the DUT pulses an ack or fail.
module tb_array_allocator;
  localparam int W = 12;
  localparam int N = 4;

  logic         clock = 1'b0, reset = 1'b1;
  logic         allocReq = 1'b0, freeReq = 1'b0;
  logic [W-1:0] freeId = '0;
  logic         allocAck, allocFail, freeAck, freeFail, sizeClear;
  logic [W-1:0] allocId, inUse, allocs;

  array_allocator #(.MemoryElementWidth(W), .NArrays(N)) dut (
    .clock(clock), .reset(reset), .allocReq(allocReq), .freeReq(freeReq), .freeId(freeId),
    .allocAck(allocAck), .allocId(allocId), .allocFail(allocFail), .freeAck(freeAck),
    .freeFail(freeFail), .sizeClear(sizeClear), .inUse(inUse), .allocs(allocs)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic aack, afail, fack, ffail, sc;
    logic [W-1:0] id, inuse, allocs;
  } rsp_t;

  rsp_t q[$];
  int total = 0, bad = 0;

  // reference model state
  int m_freed[$];
  bit m_used[N];
  int m_allocs, m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int used_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_used[i];
    return c;
  endfunction

  function automatic void model_reset();
    m_freed.delete();
    for (int i = 0; i < N; i++) m_used[i] = 0;
    m_allocs = 0;
    m_last   = 0;
  endfunction

  function automatic rsp_t cur_out();
    return '{allocAck, allocFail, freeAck, freeFail, sizeClear, allocId, inUse, allocs};
  endfunction

  task automatic step(input bit a, input bit f, input int id);
    rsp_t e;
    bit fok;
    int g;
    @(negedge clock);
    allocReq = a; freeReq = f; freeId = W'(id);
    e = '0;
    fok = f && id >= 0 && id < N && m_used[id];
    if (a && fok) begin
      e.aack = 1; e.fack = 1; e.sc = 1; m_last = id;
    end else begin
      if (f) begin
        if (fok) begin m_freed.push_back(id); m_used[id] = 0; e.fack = 1; end
        else e.ffail = 1;
      end
      if (a) begin
        g = -1;
        if (m_freed.size() > 0) g = m_freed.pop_back();
        else if (m_allocs < N) begin g = m_allocs; m_allocs++; end
        if (g >= 0) begin m_used[g] = 1; e.aack = 1; e.sc = 1; m_last = g; end
        else e.afail = 1;
      end
    end
    e.id = W'(m_last); e.inuse = W'(used_count()); e.allocs = W'(m_allocs);
    if (a || f) q.push_back(e);
  endtask

  // monitor: one expected record per cycle carrying any pulse
  always @(posedge clock) begin
    rsp_t e;
    #1;
    if (!reset && (allocAck || allocFail || freeAck || freeFail || sizeClear)) begin
      if (q.size() == 0) chk("unexpected_pulse", 64'(cur_out()), 64'(0));
      else begin
        e = q.pop_front();
        chk("response", 64'(cur_out()), 64'(e));
      end
    end
  end

  task automatic reset_mid_alloc();
    step(1, 0, 0);
    #2 reset = 1'b1;
    q.delete();
    model_reset();
    #1 chk("reset_mid_outputs", 64'(cur_out()), 64'(0));
    @(negedge clock);
    allocReq = 1'b0; freeReq = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 chk("reset_outputs", 64'(cur_out()), 64'(0));
    @(negedge clock) reset = 1'b0;

    // three fresh allocs, then fill and overflow
    repeat (3) step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    // LIFO reuse
    step(0, 1, 1); step(0, 1, 3);
    step(1, 0, 0); step(1, 0, 0);
    // double free and range error
    step(0, 1, 2); step(0, 1, 2); step(0, 1, 9);
    step(1, 0, 0);
    // bypass with all ids in use
    step(1, 1, 2);
    step(0, 0, 0);
    @(posedge clock) #2 chk("bypass_inuse", 64'(inUse), 64'(N));
    chk("bypass_allocs", 64'(allocs), 64'(N));

    reset_mid_alloc();
    step(1, 0, 0);
    step(0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      if (r == 0) reset_mid_alloc();
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 5));
    end

    step(0, 0, 0);
    repeat (3) @(negedge clock);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
